// File: rtl/axi3_slave_mem.sv
// AXI3 slave memory endpoint: one write and one read burst in flight, independent channels,
// byte-strobed word array, OKAY/SLVERR responses.
`timescale 1ns/1ps
module axi3_slave_mem #(
    parameter int unsigned     data_bus_width    = 32,
    parameter int unsigned     address_bus_width = 32,
    parameter int unsigned     id_bus_width      = 1,
    parameter int unsigned     axi_len_width     = 8,
    parameter int unsigned     mem_words         = 1024,
    parameter longint unsigned base_addr         = 64'd0
) (
    input  logic                          ACLK,
    input  logic                          ARESETn,
    input  logic [id_bus_width-1:0]       AWID,
    input  logic [address_bus_width-1:0]  AWADDR,
    input  logic [axi_len_width-1:0]      AWLEN,
    input  logic [2:0]                    AWSIZE,
    input  logic [1:0]                    AWBURST,
    input  logic                          AWVALID,
    output logic                          AWREADY,
    input  logic [id_bus_width-1:0]       WID,
    input  logic [data_bus_width-1:0]     WDATA,
    input  logic [data_bus_width/8-1:0]   WSTRB,
    input  logic                          WLAST,
    input  logic                          WVALID,
    output logic                          WREADY,
    output logic [id_bus_width-1:0]       BID,
    output logic [1:0]                    BRESP,
    output logic                          BVALID,
    input  logic                          BREADY,
    input  logic [id_bus_width-1:0]       ARID,
    input  logic [address_bus_width-1:0]  ARADDR,
    input  logic [axi_len_width-1:0]      ARLEN,
    input  logic [2:0]                    ARSIZE,
    input  logic [1:0]                    ARBURST,
    input  logic                          ARVALID,
    output logic                          ARREADY,
    output logic [id_bus_width-1:0]       RID,
    output logic [data_bus_width-1:0]     RDATA,
    output logic [1:0]                    RRESP,
    output logic                          RLAST,
    output logic                          RVALID,
    input  logic                          RREADY
);

    localparam int unsigned     BYTES     = data_bus_width / 8;
    localparam int unsigned     LSB       = $clog2(BYTES);
    localparam int unsigned     IDXW      = (mem_words > 1) ? $clog2(mem_words) : 1;
    localparam longint unsigned MEM_BYTES = 64'(mem_words) * 64'(BYTES);

    typedef logic [address_bus_width-1:0] addr_t;
    typedef logic [axi_len_width-1:0]     len_t;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

    logic [data_bus_width-1:0] mem [mem_words];

    function automatic logic in_range(input addr_t a);
        return (64'(a) >= base_addr) && (64'(a) < base_addr + MEM_BYTES);
    endfunction

    function automatic logic [IDXW-1:0] word_idx(input addr_t a);
        return IDXW'((64'(a) - base_addr) >> LSB);
    endfunction

    function automatic logic cmd_bad(input logic [2:0] size, input logic [1:0] burst, input len_t len);
        logic wrap_len_ok;
        wrap_len_ok = (len == len_t'(1)) || (len == len_t'(3)) || (len == len_t'(7)) || (len == len_t'(15));
        return (32'(size) > LSB) || (burst == 2'b11) || ((burst == 2'b10) && !wrap_len_ok);
    endfunction

    // Malformed commands step as INCR so the burst still walks a sane address sequence.
    function automatic addr_t next_addr(input addr_t a, input logic [2:0] size, input logic [1:0] burst,
                                        input len_t len, input logic bad);
        addr_t step;
        addr_t mask;
        step = addr_t'(1) << size;
        mask = ((addr_t'(len) + addr_t'(1)) << size) - addr_t'(1);
        if (bad || burst == 2'b01)
            return a + step;
        else if (burst == 2'b00)
            return a;
        else
            return (a & ~mask) | ((a + step) & mask);
    endfunction

    // ---------------- write channel ----------------
    w_state_t                  w_state, w_state_nxt;
    logic [id_bus_width-1:0]   w_id;
    addr_t                     w_addr;
    len_t                      w_len;
    len_t                      w_cnt;
    logic [2:0]                w_size;
    logic [1:0]                w_burst;
    logic                      w_bad;
    logic                      w_err;
    logic                      aw_hs;
    logic                      w_hs;
    logic                      w_final;

    assign w_final = (w_cnt == w_len);
    assign aw_hs   = AWVALID && AWREADY;
    assign w_hs    = WVALID && WREADY;
    assign BID     = w_id;
    assign BRESP   = (BVALID && w_err) ? 2'b10 : 2'b00;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn)
            w_state <= W_IDLE;
        else
            w_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = w_state;
        AWREADY     = 1'b0;
        WREADY      = 1'b0;
        BVALID      = 1'b0;
        case (w_state)
            W_IDLE: begin
                AWREADY = 1'b1;
                if (AWVALID) w_state_nxt = W_DATA;
            end
            W_DATA: begin
                WREADY = 1'b1;
                if (WVALID && w_final) w_state_nxt = W_RESP;
            end
            W_RESP: begin
                BVALID = 1'b1;
                if (BREADY) w_state_nxt = W_IDLE;
            end
            default: w_state_nxt = W_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            w_id    <= '0;
            w_addr  <= '0;
            w_len   <= '0;
            w_cnt   <= '0;
            w_size  <= '0;
            w_burst <= '0;
            w_bad   <= 1'b0;
            w_err   <= 1'b0;
        end else if (aw_hs) begin
            w_id    <= AWID;
            w_addr  <= AWADDR;
            w_len   <= AWLEN;
            w_cnt   <= '0;
            w_size  <= AWSIZE;
            w_burst <= AWBURST;
            w_bad   <= cmd_bad(AWSIZE, AWBURST, AWLEN);
            w_err   <= cmd_bad(AWSIZE, AWBURST, AWLEN);
        end else if (w_hs) begin
            w_addr <= next_addr(w_addr, w_size, w_burst, w_len, w_bad);
            w_cnt  <= w_cnt + len_t'(1);
            if (!in_range(w_addr) || (WID != w_id) || (WLAST != w_final))
                w_err <= 1'b1;
        end
    end

    always_ff @(posedge ACLK) begin
        if (w_hs && in_range(w_addr)) begin
            for (int unsigned b = 0; b < BYTES; b++) begin
                if (WSTRB[b]) mem[word_idx(w_addr)][8*b +: 8] <= WDATA[8*b +: 8];
            end
        end
    end

    // ---------------- read channel ----------------
    r_state_t                  r_state, r_state_nxt;
    logic [id_bus_width-1:0]   r_id;
    addr_t                     r_addr;
    len_t                      r_len;
    len_t                      r_cnt;
    logic [2:0]                r_size;
    logic [1:0]                r_burst;
    logic                      r_bad;
    logic                      ar_hs;
    logic                      r_hs;
    addr_t                     fetch_addr;
    logic                      fetch_bad;
    logic                      fetch_ok;
    logic [data_bus_width-1:0] fetch_data;
    logic [1:0]                fetch_resp;

    assign ar_hs = ARVALID && ARREADY;
    assign r_hs  = RVALID && RREADY;
    assign RID   = r_id;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn)
            r_state <= R_IDLE;
        else
            r_state <= r_state_nxt;
    end

    always_comb begin
        r_state_nxt = r_state;
        ARREADY     = 1'b0;
        RVALID      = 1'b0;
        case (r_state)
            R_IDLE: begin
                ARREADY = 1'b1;
                if (ARVALID) r_state_nxt = R_DATA;
            end
            R_DATA: begin
                RVALID = 1'b1;
                if (RREADY && RLAST) r_state_nxt = R_IDLE;
            end
            default: r_state_nxt = R_IDLE;
        endcase
    end

    // The first beat is fetched on the AR edge itself, later beats from the stepped address.
    always_comb begin
        fetch_addr = ar_hs ? ARADDR : r_addr;
        fetch_bad  = ar_hs ? cmd_bad(ARSIZE, ARBURST, ARLEN) : r_bad;
        fetch_ok   = in_range(fetch_addr);
        fetch_data = fetch_ok ? mem[word_idx(fetch_addr)] : '0;
        fetch_resp = (fetch_bad || !fetch_ok) ? 2'b10 : 2'b00;
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_id    <= '0;
            r_addr  <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_size  <= '0;
            r_burst <= '0;
            r_bad   <= 1'b0;
            RDATA   <= '0;
            RRESP   <= 2'b00;
            RLAST   <= 1'b0;
        end else if (ar_hs) begin
            r_id    <= ARID;
            r_len   <= ARLEN;
            r_cnt   <= '0;
            r_size  <= ARSIZE;
            r_burst <= ARBURST;
            r_bad   <= fetch_bad;
            r_addr  <= next_addr(ARADDR, ARSIZE, ARBURST, ARLEN, fetch_bad);
            RDATA   <= fetch_data;
            RRESP   <= fetch_resp;
            RLAST   <= (ARLEN == '0);
        end else if (r_hs) begin
            if (RLAST) begin
                RDATA <= '0;
                RRESP <= 2'b00;
                RLAST <= 1'b0;
            end else begin
                r_addr <= next_addr(r_addr, r_size, r_burst, r_len, r_bad);
                r_cnt  <= r_cnt + len_t'(1);
                RDATA  <= fetch_data;
                RRESP  <= fetch_resp;
                RLAST  <= ((r_cnt + len_t'(1)) == r_len);
            end
        end
    end

endmodule

// File: tb/tb_axi3_slave_mem.sv
// Scoreboard bench for axi3_slave_mem: directed bursts push expected B/R responses,
// a negedge monitor pops and compares them as the DUT presents them.
`timescale 1ns/1ps
module tb_axi3_slave_mem;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int IW = 1;
    localparam int LW = 8;

    logic            ACLK = 1'b0;
    logic            ARESETn = 1'b0;
    logic [IW-1:0]   AWID = '0;
    logic [AW-1:0]   AWADDR = '0;
    logic [LW-1:0]   AWLEN = '0;
    logic [2:0]      AWSIZE = '0;
    logic [1:0]      AWBURST = '0;
    logic            AWVALID = 1'b0;
    logic            AWREADY;
    logic [IW-1:0]   WID = '0;
    logic [DW-1:0]   WDATA = '0;
    logic [DW/8-1:0] WSTRB = '0;
    logic            WLAST = 1'b0;
    logic            WVALID = 1'b0;
    logic            WREADY;
    logic [IW-1:0]   BID;
    logic [1:0]      BRESP;
    logic            BVALID;
    logic            BREADY = 1'b1;
    logic [IW-1:0]   ARID = '0;
    logic [AW-1:0]   ARADDR = '0;
    logic [LW-1:0]   ARLEN = '0;
    logic [2:0]      ARSIZE = '0;
    logic [1:0]      ARBURST = '0;
    logic            ARVALID = 1'b0;
    logic            ARREADY;
    logic [IW-1:0]   RID;
    logic [DW-1:0]   RDATA;
    logic [1:0]      RRESP;
    logic            RLAST;
    logic            RVALID;
    logic            RREADY = 1'b1;

    always #5 ACLK = ~ACLK;

    axi3_slave_mem #(
        .data_bus_width(DW), .address_bus_width(AW), .id_bus_width(IW),
        .axi_len_width(LW), .mem_words(1024), .base_addr(64'd0)
    ) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WID(WID), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
    );

    typedef struct packed { logic [IW-1:0] id; logic [1:0] resp; } b_exp_t;
    typedef struct packed { logic [IW-1:0] id; logic [DW-1:0] data; logic [1:0] resp; logic last; } r_exp_t;

    b_exp_t        bq[$];
    r_exp_t        rq[$];
    int            vectors = 0;
    int            miscompares = 0;
    logic          rr_toggle = 1'b0;
    logic [DW-1:0] wd [16];
    logic [3:0]    ws [16];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge ACLK) begin : monitor
        b_exp_t be;
        r_exp_t re;
        if (ARESETn) begin
            if (BVALID && BREADY) begin
                if (bq.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL b_unexpected: got BID %h BRESP %b expected no response", BID, BRESP);
                end else begin
                    be = bq.pop_front();
                    check("bid", 64'(BID), 64'(be.id));
                    check("bresp", 64'(BRESP), 64'(be.resp));
                end
            end
            if (RVALID) begin
                if (rq.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL r_unexpected: got RDATA %h expected no beat", RDATA);
                end else if (RREADY) begin
                    re = rq.pop_front();
                    check("rid", 64'(RID), 64'(re.id));
                    check("rdata", 64'(RDATA), 64'(re.data));
                    check("rresp", 64'(RRESP), 64'(re.resp));
                    check("rlast", 64'(RLAST), 64'(re.last));
                end else begin
                    re = rq[0];
                    check("rdata_stall", 64'(RDATA), 64'(re.data));
                    check("rlast_stall", 64'(RLAST), 64'(re.last));
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge ACLK); #1;
            RREADY = rr_toggle ? !RREADY : 1'b1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    task automatic wait_drain(input string tag);
        int n = 0;
        while ((bq.size() != 0 || rq.size() != 0) && n < 200) begin
            @(posedge ACLK); #1; n++;
        end
        if (bq.size() != 0 || rq.size() != 0) begin
            vectors++; miscompares++;
            $display("FAIL %s_timeout: got %0d pending expected 0", tag, bq.size() + rq.size());
            bq.delete();
            rq.delete();
        end
    endtask

    task automatic push_r(input logic [IW-1:0] id, input logic [DW-1:0] d, input logic [1:0] resp, input logic last);
        r_exp_t e;
        e.id = id; e.data = d; e.resp = resp; e.last = last;
        rq.push_back(e);
    endtask

    task automatic do_write(input logic [IW-1:0] id, input logic [IW-1:0] wid, input logic [AW-1:0] addr,
                            input int len, input logic [1:0] burst, input int last_at, input logic [1:0] exp_resp);
        b_exp_t e;
        int n;
        e.id = id; e.resp = exp_resp;
        bq.push_back(e);
        @(posedge ACLK); #1;
        AWID = id; AWADDR = addr; AWLEN = LW'(len); AWSIZE = 3'd2; AWBURST = burst; AWVALID = 1'b1;
        n = 0;
        while (!AWREADY && n < 50) begin @(posedge ACLK); #1; n++; end
        @(posedge ACLK); #1;
        AWVALID = 1'b0;
        check("wready_after_aw", 64'(WREADY), 64'd1);
        for (int i = 0; i <= len; i++) begin
            WID = wid; WDATA = wd[i]; WSTRB = ws[i]; WLAST = (i == last_at); WVALID = 1'b1;
            n = 0;
            while (!WREADY && n < 50) begin @(posedge ACLK); #1; n++; end
            @(posedge ACLK); #1;
        end
        WVALID = 1'b0; WLAST = 1'b0;
        wait_drain("write");
    endtask

    task automatic do_read(input logic [IW-1:0] id, input logic [AW-1:0] addr, input int len, input logic [1:0] burst);
        int n;
        @(posedge ACLK); #1;
        ARID = id; ARADDR = addr; ARLEN = LW'(len); ARSIZE = 3'd2; ARBURST = burst; ARVALID = 1'b1;
        n = 0;
        while (!ARREADY && n < 50) begin @(posedge ACLK); #1; n++; end
        @(posedge ACLK); #1;
        ARVALID = 1'b0;
        wait_drain("read");
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_awready"}, 64'(AWREADY), 64'd1);
        check({tag, "_arready"}, 64'(ARREADY), 64'd1);
        check({tag, "_wready"},  64'(WREADY),  64'd0);
        check({tag, "_bvalid"},  64'(BVALID),  64'd0);
        check({tag, "_rvalid"},  64'(RVALID),  64'd0);
        check({tag, "_rlast"},   64'(RLAST),   64'd0);
        check({tag, "_bresp"},   64'(BRESP),   64'd0);
        check({tag, "_rresp"},   64'(RRESP),   64'd0);
        check({tag, "_bid"},     64'(BID),     64'd0);
        check({tag, "_rid"},     64'(RID),     64'd0);
        check({tag, "_rdata"},   64'(RDATA),   64'd0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin wd[i] = '0; ws[i] = 4'hF; end
        repeat (3) @(posedge ACLK);
        #1;
        reset_checks("rst");
        ARESETn = 1'b1;

        // INCR write then read back
        wd[0] = 32'h11111111; wd[1] = 32'h22222222; wd[2] = 32'h33333333; wd[3] = 32'h44444444;
        do_write(1'b1, 1'b1, 32'h10, 3, 2'b01, 3, 2'b00);
        push_r(1'b1, 32'h11111111, 2'b00, 1'b0);
        push_r(1'b1, 32'h22222222, 2'b00, 1'b0);
        push_r(1'b1, 32'h33333333, 2'b00, 1'b0);
        push_r(1'b1, 32'h44444444, 2'b00, 1'b1);
        do_read(1'b1, 32'h10, 3, 2'b01);

        // Partial strobe merge
        wd[0] = 32'hFFFFFFFF;
        do_write(1'b0, 1'b0, 32'h40, 0, 2'b01, 0, 2'b00);
        wd[0] = 32'hAABBCCDD; ws[0] = 4'b0011;
        do_write(1'b0, 1'b0, 32'h40, 0, 2'b01, 0, 2'b00);
        ws[0] = 4'hF;
        push_r(1'b0, 32'hFFFFCCDD, 2'b00, 1'b1);
        do_read(1'b0, 32'h40, 0, 2'b01);

        // WRAP read over the INCR data
        push_r(1'b1, 32'h33333333, 2'b00, 1'b0);
        push_r(1'b1, 32'h44444444, 2'b00, 1'b0);
        push_r(1'b1, 32'h11111111, 2'b00, 1'b0);
        push_r(1'b1, 32'h22222222, 2'b00, 1'b1);
        do_read(1'b1, 32'h18, 3, 2'b10);

        // FIXED write keeps the last beat
        wd[0] = 32'd1; wd[1] = 32'd2; wd[2] = 32'd3;
        do_write(1'b0, 1'b0, 32'h50, 2, 2'b00, 2, 2'b00);
        push_r(1'b0, 32'd3, 2'b00, 1'b1);
        do_read(1'b0, 32'h50, 0, 2'b01);

        // Reserved burst read: SLVERR every beat, INCR addressing
        push_r(1'b0, 32'h11111111, 2'b10, 1'b0);
        push_r(1'b0, 32'h22222222, 2'b10, 1'b1);
        do_read(1'b0, 32'h10, 1, 2'b11);

        // Burst running off the end of the array
        wd[0] = 32'hDEAD0000;
        do_write(1'b0, 1'b0, 32'h0, 0, 2'b01, 0, 2'b00);
        wd[0] = 32'hA5A5A5A5; wd[1] = 32'h5A5A5A5A;
        do_write(1'b1, 1'b1, 32'hFFC, 1, 2'b01, 1, 2'b10);
        push_r(1'b1, 32'hA5A5A5A5, 2'b00, 1'b0);
        push_r(1'b1, 32'h00000000, 2'b10, 1'b1);
        do_read(1'b1, 32'hFFC, 1, 2'b01);
        push_r(1'b0, 32'hDEAD0000, 2'b00, 1'b1);
        do_read(1'b0, 32'h0, 0, 2'b01);

        // Early WLAST, then WID mismatch: all beats still taken and stored
        for (int i = 0; i < 4; i++) wd[i] = 32'hC0DE0000 + 32'(i);
        do_write(1'b0, 1'b0, 32'h60, 3, 2'b01, 1, 2'b10);
        for (int i = 0; i < 4; i++) wd[i] = 32'hC0DE0010 + 32'(i);
        do_write(1'b1, 1'b0, 32'h70, 3, 2'b01, 3, 2'b10);
        rr_toggle = 1'b1;
        for (int i = 0; i < 4; i++) push_r(1'b1, 32'hC0DE0000 + 32'(i), 2'b00, i == 3);
        do_read(1'b1, 32'h60, 3, 2'b01);
        for (int i = 0; i < 4; i++) push_r(1'b1, 32'hC0DE0010 + 32'(i), 2'b00, i == 3);
        do_read(1'b1, 32'h70, 3, 2'b01);
        rr_toggle = 1'b0;
        @(posedge ACLK); #1;

        // Reset in the middle of a write burst
        @(posedge ACLK); #1;
        AWID = 1'b1; AWADDR = 32'h80; AWLEN = 8'd3; AWSIZE = 3'd2; AWBURST = 2'b01; AWVALID = 1'b1;
        @(posedge ACLK); #1;
        AWVALID = 1'b0;
        WID = 1'b1; WDATA = 32'hBEEF0080; WSTRB = 4'hF; WLAST = 1'b0; WVALID = 1'b1;
        @(posedge ACLK); #1;
        check("wready_mid_burst", 64'(WREADY), 64'd1);
        ARESETn = 1'b0;
        WVALID = 1'b0;
        #1;
        reset_checks("rst_mid");
        @(posedge ACLK); #1;
        ARESETn = 1'b1;
        wd[0] = 32'h12345678;
        do_write(1'b1, 1'b1, 32'h84, 0, 2'b01, 0, 2'b00);
        push_r(1'b1, 32'hBEEF0080, 2'b00, 1'b0);
        push_r(1'b1, 32'h12345678, 2'b00, 1'b1);
        do_read(1'b1, 32'h80, 1, 2'b01);

        repeat (2) @(posedge ACLK);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
